// File: rtl/encoder_read_sequencer.sv
// Master for the 24-bit serial absolute encoder link. Generates the shift
// clock, hunts for the start bit, shifts in one frame, publishes the position
// and status flags, then holds sck high for the encoder recovery time.
module encoder_read_sequencer #(
  parameter int CLK_DIV         = 4,
  parameter int FRAME_BITS      = 24,
  parameter int POS_MSB         = 21,
  parameter int POS_LSB         = 3,
  parameter int START_TIMEOUT   = 16,
  parameter int RECOVERY_CYCLES = 200,
  parameter int PERIOD_CYCLES   = 10000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       period_en,
  input  logic                       miso,
  output logic                       sck,
  output logic                       busy,
  output logic [FRAME_BITS-1:0]      frame,
  output logic [POS_MSB-POS_LSB:0]   encoder_val,
  output logic                       data_valid,
  output logic                       err_encoder,
  output logic                       warn,
  output logic                       err_timeout
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int BIT_W = $clog2(FRAME_BITS + 1);
  localparam int TO_W  = $clog2(START_TIMEOUT + 1);
  localparam int REC_W = $clog2(RECOVERY_CYCLES);
  localparam int PER_W = $clog2(PERIOD_CYCLES);
  localparam int POS_W = POS_MSB - POS_LSB + 1;

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_FULL  = BIT_W'(FRAME_BITS);
  localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(START_TIMEOUT - 1);
  localparam logic [REC_W-1:0] REC_LAST  = REC_W'(RECOVERY_CYCLES - 1);
  localparam logic [PER_W-1:0] PER_LAST  = PER_W'(PERIOD_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_START,
    SHIFT,
    RECOVER
  } state_t;

  state_t                  state_q, state_d;
  logic [DIV_W-1:0]        div_q, div_d;
  logic                    sck_q, sck_d;
  logic [BIT_W-1:0]        bit_q, bit_d;
  logic [TO_W-1:0]         to_q, to_d;
  logic [REC_W-1:0]        rec_q, rec_d;
  logic [PER_W-1:0]        per_q, per_d;
  logic [FRAME_BITS-1:0]   shreg_q, shreg_d;
  logic [FRAME_BITS-1:0]   frame_q, frame_d;
  logic [POS_W-1:0]        enc_q, enc_d;
  logic                    err_enc_q, err_enc_d;
  logic                    warn_q, warn_d;
  logic                    dv_q, dv_d;
  logic                    eto_q, eto_d;
  logic                    sync1_q, sync2_q;

  logic                    miso_s;
  logic                    div_term;
  logic                    sck_rise;
  logic                    trigger;

  assign miso_s   = sync2_q;
  assign div_term = (div_q == DIV_LAST);
  assign sck_rise = div_term && !sck_q;
  assign trigger  = start || (period_en && (per_q == PER_LAST));

  // Two-flop synchroniser for the asynchronous encoder data line; idles high.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= miso;
      sync2_q <= sync1_q;
    end
  end

  // State, counters and published results.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      div_q     <= '0;
      sck_q     <= 1'b1;
      bit_q     <= '0;
      to_q      <= '0;
      rec_q     <= '0;
      per_q     <= '0;
      shreg_q   <= '0;
      frame_q   <= '0;
      enc_q     <= '0;
      err_enc_q <= 1'b0;
      warn_q    <= 1'b0;
      dv_q      <= 1'b0;
      eto_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      sck_q     <= sck_d;
      bit_q     <= bit_d;
      to_q      <= to_d;
      rec_q     <= rec_d;
      per_q     <= per_d;
      shreg_q   <= shreg_d;
      frame_q   <= frame_d;
      enc_q     <= enc_d;
      err_enc_q <= err_enc_d;
      warn_q    <= warn_d;
      dv_q      <= dv_d;
      eto_q     <= eto_d;
    end
  end

  // Next-state logic: trigger handling, sck divider, start-bit hunt, shifting,
  // publishing and the recovery hold. The period counter saturates so that an
  // expiry landing while busy is served on the first IDLE cycle.
  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    sck_d     = sck_q;
    bit_d     = bit_q;
    to_d      = to_q;
    rec_d     = rec_q;
    shreg_d   = shreg_q;
    frame_d   = frame_q;
    enc_d     = enc_q;
    err_enc_d = err_enc_q;
    warn_d    = warn_q;
    dv_d      = 1'b0;
    eto_d     = 1'b0;

    if (!period_en) begin
      per_d = '0;
    end else if (per_q != PER_LAST) begin
      per_d = per_q + PER_W'(1);
    end else begin
      per_d = per_q;
    end

    case (state_q)
      IDLE: begin
        sck_d = 1'b1;
        if (trigger) begin
          state_d = WAIT_START;
          div_d   = '0;
          to_d    = '0;
          per_d   = '0;
        end
      end

      WAIT_START: begin
        if (div_term) begin
          div_d = '0;
          sck_d = ~sck_q;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
        if (sck_rise) begin
          if (!miso_s) begin
            state_d = SHIFT;
            bit_d   = '0;
          end else if (to_q == TO_LAST) begin
            to_d    = to_q + TO_W'(1);
            eto_d   = 1'b1;
            sck_d   = 1'b1;
            rec_d   = '0;
            state_d = RECOVER;
          end else begin
            to_d = to_q + TO_W'(1);
          end
        end
      end

      SHIFT: begin
        if (bit_q == BIT_FULL) begin
          frame_d   = shreg_q;
          enc_d     = shreg_q[POS_MSB:POS_LSB];
          err_enc_d = ~shreg_q[FRAME_BITS-1];
          warn_d    = ~shreg_q[FRAME_BITS-2];
          dv_d      = 1'b1;
          sck_d     = 1'b1;
          rec_d     = '0;
          state_d   = RECOVER;
        end else begin
          if (div_term) begin
            div_d = '0;
            sck_d = ~sck_q;
          end else begin
            div_d = div_q + DIV_W'(1);
          end
          if (sck_rise) begin
            shreg_d = {shreg_q[FRAME_BITS-2:0], miso_s};
            bit_d   = bit_q + BIT_W'(1);
          end
        end
      end

      RECOVER: begin
        sck_d = 1'b1;
        if (rec_q == REC_LAST) begin
          state_d = IDLE;
        end else begin
          rec_d = rec_q + REC_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
        sck_d   = 1'b1;
      end
    endcase
  end

  assign sck         = sck_q;
  assign busy        = (state_q != IDLE);
  assign frame       = frame_q;
  assign encoder_val = enc_q;
  assign data_valid  = dv_q;
  assign err_encoder = err_enc_q;
  assign warn        = warn_q;
  assign err_timeout = eto_q;

endmodule

// File: tb/tb_encoder_read_sequencer.sv
// Directed bench for encoder_read_sequencer with a behavioural encoder that
// presents the start bit and frame bits on falling sck edges.
module tb_encoder_read_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        periodEn = 1'b0;
  logic        miso = 1'b1;
  logic        sck;
  logic        busy;
  logic [23:0] frame;
  logic [18:0] encoderVal;
  logic        dataValid;
  logic        errEncoder;
  logic        warn;
  logic        errTimeout;

  int checkCount = 0;
  int passCount = 0;
  int cycleNum = 0;
  int dvTotal = 0;

  logic [23:0] modelFrame = 24'hC12348;
  int          modelExtra = 0;
  int          modelIdx = 0;
  logic        modelSckQ = 1'b1;
  logic        modelBusyQ = 1'b0;

  bit   monEnable = 1'b0;
  int   runLen = 1000;
  logic monSckQ = 1'b1;
  int   badLow = 0;
  int   badHigh = 0;

  encoder_read_sequencer #(
    .CLK_DIV(4),
    .FRAME_BITS(24),
    .POS_MSB(21),
    .POS_LSB(3),
    .START_TIMEOUT(16),
    .RECOVERY_CYCLES(200),
    .PERIOD_CYCLES(500)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .period_en(periodEn),
    .miso(miso),
    .sck(sck),
    .busy(busy),
    .frame(frame),
    .encoder_val(encoderVal),
    .data_valid(dataValid),
    .err_encoder(errEncoder),
    .warn(warn),
    .err_timeout(errTimeout)
  );

  // Free-running system clock.
  always #5 clk = ~clk;

  // Cycle index and count of data_valid pulses seen.
  always @(posedge clk) begin
    cycleNum++;
    if (dataValid === 1'b1) dvTotal++;
  end

  // Bit the encoder presents on its idx-th falling sck edge of a read.
  function automatic logic modelBit(input int idx);
    int k;
    if (idx < modelExtra) return 1'b1;
    if (idx == modelExtra) return 1'b0;
    k = idx - modelExtra - 1;
    if (k < 24) return modelFrame[23 - k];
    return 1'b1;
  endfunction

  // Encoder model: restarts on each new read, idles high, updates on sck fall.
  always @(posedge clk) begin
    #1;
    if (busy && !modelBusyQ) modelIdx = 0;
    if (!busy) begin
      miso = 1'b1;
    end else if (!sck && modelSckQ) begin
      miso = modelBit(modelIdx);
      modelIdx++;
    end
    modelSckQ = sck;
    modelBusyQ = busy;
  end

  // sck phase monitor: low phases must be 4 cycles, high phases 4 or >= 200.
  always @(negedge clk) begin
    if (monEnable) begin
      if (sck == monSckQ) begin
        runLen++;
      end else begin
        if (monSckQ == 1'b0 && runLen != 4) badLow++;
        if (monSckQ == 1'b1 && runLen != 4 && runLen < 200) badHigh++;
        runLen = 1;
      end
    end else begin
      runLen = 1000;
    end
    monSckQ = sck;
  end

  // Hard stop if the sequence ever stalls.
  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed === expected) passCount++;
    else $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
  endtask

  task automatic applyStimulus(input logic [23:0] frm, input int extra, output int trig);
    modelFrame = frm;
    modelExtra = extra;
    @(negedge clk);
    start = 1'b1;
    trig = cycleNum;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic waitForDv(input int budget, output int cyc);
    cyc = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (dataValid === 1'b1) begin
        cyc = cycleNum;
        break;
      end
    end
  endtask

  task automatic waitForIdle(input int budget, output int cyc);
    cyc = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (busy === 1'b0) begin
        cyc = cycleNum;
        break;
      end
    end
  endtask

  int trig, cyc, idleCyc, dv0, lowCnt, pStart, nDv;
  int dvCyc[8];

  initial begin
    repeat (3) @(negedge clk);
    checkOutput("resetSck", sck, 1);
    checkOutput("resetBusy", busy, 0);
    checkOutput("resetDv", dataValid, 0);
    checkOutput("resetTimeout", errTimeout, 0);
    checkOutput("resetFrame", frame, 0);
    checkOutput("resetEnc", encoderVal, 0);
    checkOutput("resetErrEnc", errEncoder, 0);
    checkOutput("resetWarn", warn, 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    $display("[TB] good frame");
    applyStimulus(24'hC12348, 0, trig);
    waitForDv(400, cyc);
    checkOutput("goodLatency", cyc - trig, 202);
    checkOutput("goodEnc", encoderVal, 19'h02469);
    checkOutput("goodFrame", frame, 24'hC12348);
    checkOutput("goodErrEnc", errEncoder, 0);
    checkOutput("goodWarn", warn, 0);
    @(negedge clk);
    checkOutput("goodDvPulse", dataValid, 0);
    checkOutput("goodSckHeld", sck, 1);
    waitForIdle(400, idleCyc);
    checkOutput("goodIdleAt", idleCyc - trig, 402);

    $display("[TB] error and warning frame");
    applyStimulus(24'h012348, 0, trig);
    waitForDv(400, cyc);
    checkOutput("errLatency", cyc - trig, 202);
    checkOutput("errEnc", encoderVal, 19'h02469);
    checkOutput("errErrEnc", errEncoder, 1);
    checkOutput("errWarn", warn, 1);
    @(negedge clk);
    checkOutput("errDvPulse", dataValid, 0);
    waitForIdle(400, idleCyc);

    $display("[TB] late start bit");
    applyStimulus(24'hA5A5A5, 2, trig);
    waitForDv(400, cyc);
    checkOutput("lateLatency", cyc - trig, 218);
    checkOutput("lateEnc", encoderVal, 19'h4B4B4);
    checkOutput("lateErrEnc", errEncoder, 0);
    checkOutput("lateWarn", warn, 1);
    waitForIdle(400, idleCyc);

    $display("[TB] start timeout");
    repeat (2) @(negedge clk);
    dv0 = dvTotal;
    applyStimulus(24'h000000, 1000, trig);
    cyc = -1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (errTimeout === 1'b1) begin
        cyc = cycleNum;
        break;
      end
    end
    checkOutput("toLatency", cyc - trig, 129);
    @(negedge clk);
    checkOutput("toPulse", errTimeout, 0);
    lowCnt = 0;
    idleCyc = -1;
    for (int i = 0; i < 400; i++) begin
      if (busy === 1'b0) begin
        idleCyc = cycleNum;
        break;
      end
      if (sck !== 1'b1) lowCnt++;
      @(negedge clk);
    end
    checkOutput("toSckHigh", lowCnt, 0);
    checkOutput("toIdleAt", idleCyc - trig, 329);
    repeat (2) @(negedge clk);
    checkOutput("toNoDv", dvTotal - dv0, 0);
    checkOutput("toFrameKept", frame, 24'hA5A5A5);
    checkOutput("toEncKept", encoderVal, 19'h4B4B4);

    $display("[TB] start while busy");
    dv0 = dvTotal;
    applyStimulus(24'hC12348, 0, trig);
    idleCyc = -1;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      start = (cycleNum == trig + 10) || (cycleNum == trig + 100);
      if (busy === 1'b0) begin
        idleCyc = cycleNum;
        break;
      end
    end
    start = 1'b0;
    checkOutput("dropIdleAt", idleCyc - trig, 402);
    repeat (5) @(negedge clk);
    checkOutput("dropOneDv", dvTotal - dv0, 1);
    checkOutput("dropNoQueue", busy, 0);
    applyStimulus(24'h012348, 0, trig);
    waitForDv(400, cyc);
    checkOutput("dropNextLatency", cyc - trig, 202);
    checkOutput("dropNextFrame", frame, 24'h012348);
    waitForIdle(400, idleCyc);

    $display("[TB] reset mid-shift");
    repeat (2) @(negedge clk);
    dv0 = dvTotal;
    applyStimulus(24'hC12348, 0, trig);
    while (cycleNum < trig + 90) @(negedge clk);
    checkOutput("rstBusyBefore", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("rstBusy", busy, 0);
    checkOutput("rstSck", sck, 1);
    checkOutput("rstFrame", frame, 0);
    checkOutput("rstEnc", encoderVal, 0);
    checkOutput("rstErrEnc", errEncoder, 0);
    checkOutput("rstWarn", warn, 0);
    checkOutput("rstDv", dataValid, 0);
    repeat (300) @(negedge clk);
    checkOutput("rstNoDv", dvTotal - dv0, 0);
    applyStimulus(24'h012348, 0, trig);
    waitForDv(400, cyc);
    checkOutput("rstNextLatency", cyc - trig, 202);
    checkOutput("rstNextEnc", encoderVal, 19'h02469);
    checkOutput("rstNextErrEnc", errEncoder, 1);
    checkOutput("rstNextWarn", warn, 1);
    waitForIdle(400, idleCyc);

    $display("[TB] periodic reads");
    modelFrame = 24'hC12348;
    modelExtra = 0;
    repeat (2) @(negedge clk);
    monEnable = 1'b1;
    nDv = 0;
    periodEn = 1'b1;
    pStart = cycleNum;
    while (cycleNum < pStart + 2700) begin
      @(negedge clk);
      periodEn = (cycleNum <= pStart + 1999);
      if (dataValid === 1'b1 && nDv < 8) begin
        dvCyc[nDv] = cycleNum;
        nDv++;
      end
    end
    monEnable = 1'b0;
    checkOutput("perCount", nDv, 4);
    checkOutput("perFirst", dvCyc[0] - pStart, 701);
    for (int i = 1; i < 4; i++) checkOutput("perSpacing", dvCyc[i] - dvCyc[i-1], 500);
    checkOutput("perSckLow", badLow, 0);
    checkOutput("perSckHigh", badHigh, 0);
    checkOutput("perEnc", encoderVal, 19'h02469);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/encoder_read_sequencer.md
Name: encoder_read_sequencer

Overview:
- System-clock-domain master for the 24-bit serial absolute encoder link.
- Generates the encoder shift clock (sck), detects the start bit, and shifts in one frame.
- Extracts the 19-bit position and the status flags, and enforces the encoder recovery (monoflop) time between frames.
- Reads are requested by a pulse or run periodically; the results feed the motor-control register file.

Parameters:
- CLK_DIV, 4: sck half-period in clk cycles; minimum 3.
- FRAME_BITS, 24: data bits per frame after the start bit.
- POS_MSB, 21: position field MSB within the frame.
- POS_LSB, 3: position field LSB; position width = POS_MSB-POS_LSB+1 = 19.
- START_TIMEOUT, 16: sck rising edges allowed in WAIT_START before abort.
- RECOVERY_CYCLES, 200: clk cycles sck is held high after each frame.
- PERIOD_CYCLES, 10000: clk cycles between auto-started reads.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- start  in  1  one-cycle read request.
- period_en  in  1  enables periodic auto-start.
- miso  in  1  encoder data, asynchronous to clk.
- sck  out  1  encoder shift clock; idle high.
- busy  out  1  high in any state other than IDLE.
- frame  out  FRAME_BITS  last complete raw frame, MSB first.
- encoder_val  out  19  frame[POS_MSB:POS_LSB] of last good-length frame.
- data_valid  out  1  one-cycle pulse; frame, encoder_val and flags updated.
- err_encoder  out  1  frame[23]==0 (encoder error, active-low bit); valid with data_valid.
- warn  out  1  frame[22]==0 (warning, active-low bit); valid with data_valid.
- err_timeout  out  1  one-cycle pulse; no start bit seen.

Behaviour:
- Reset values (rst high at a clk edge): state=IDLE, sck=1, busy=0, data_valid=0, err_timeout=0, frame=0, encoder_val=0, err_encoder=0, warn=0; all counters=0; synchroniser flops=1.
- miso passes through a 2-flop synchroniser (miso_s).
- sck_rise is the clk cycle in which sck is driven 0->1; miso_s is sampled in that cycle.
- States IDLE, WAIT_START, SHIFT, RECOVER.
- IDLE:
  - sck=1.
  - The period counter runs only while period_en=1; it is cleared when period_en=0.
  - Trigger = start, OR (period_en AND period counter == PERIOD_CYCLES-1).
  - On trigger: go to WAIT_START next cycle; clear the divider, timeout counter and period counter.
- sck generation (WAIT_START and SHIFT only):
  - Divider counts 0..CLK_DIV-1; at terminal count, sck toggles.
  - The first toggle, to 0, occurs CLK_DIV cycles after entering WAIT_START.
  - sck period = 2*CLK_DIV clk cycles, 50% duty.
- WAIT_START:
  - On each sck_rise: if miso_s==0, go to SHIFT with bit counter=0.
  - Otherwise increment the timeout counter; on reaching START_TIMEOUT, pulse err_timeout, set sck=1, and go to RECOVER.
- SHIFT:
  - On each sck_rise: shreg <= {shreg[FRAME_BITS-2:0], miso_s}; bit counter++.
  - When the FRAME_BITS-th bit is shifted in, in the following cycle:
    - frame <= shreg; encoder_val <= shreg[POS_MSB:POS_LSB]; err_encoder <= ~shreg[23]; warn <= ~shreg[22]; data_valid=1 for exactly one cycle.
    - sck is held at 1; go to RECOVER.
- RECOVER:
  - sck=1; count RECOVERY_CYCLES clk cycles, then go to IDLE.
  - The period counter keeps running in RECOVER; a period expiry that lands in RECOVER is deferred to the first IDLE cycle, not dropped.
- Triggers while busy=1: an explicit start is dropped (no queue). The periodic trigger is deferred as described under RECOVER.
- start and period expiry in the same IDLE cycle produce a single read.
- Read latency from trigger to data_valid, with the start bit present on the first sck_rise:
  - 2*CLK_DIV*(FRAME_BITS+1) + 2 clk cycles.
  - Each extra sck_rise before the start bit adds 2*CLK_DIV.
- Outputs frame, encoder_val, err_encoder and warn hold their values between data_valid pulses; err_timeout does not modify them.
- rst asserted mid-frame: state returns to IDLE at that edge, and sck=1 the following cycle. No partial data is published and no data_valid is issued.
- Counter widths are sized by $clog2 of the respective parameter; period and recovery counters do not wrap in their states.

Test Plan:
- Good frame: CLK_DIV=4; start pulse; model drives start bit then 24'hC12348 -> data_valid once at trigger+202 cycles; encoder_val=19'h02469; frame=24'hC12348; err_encoder=0; warn=0.
- Error/warn frame: model returns 24'h012348 -> encoder_val=19'h02469, err_encoder=1, warn=1, data_valid=1 for one cycle.
- Timeout: miso held 1 -> err_timeout pulse on the 16th sck_rise; no data_valid; frame/encoder_val unchanged; sck=1 for 200 cycles, then busy=0.
- Busy drop: start pulses at trigger+10 and trigger+100 -> exactly one frame and one data_valid; the next start after busy=0 begins a new read.
- Periodic: PERIOD_CYCLES=500, period_en=1 for 2000 cycles -> 4 reads, triggers 500 cycles apart; sck high for at least 200 cycles between frames; sck half-periods exactly 4 cycles.
- Reset mid-SHIFT: rst for 1 cycle at bit 10 -> busy=0 and sck=1 next cycle; all outputs 0; no data_valid; the subsequent start yields a correct frame.
